mem_requester: RTL and testbench

- Initiator for the memory-unit request handshake: it accepts CPU load/store requests into a small FIFO.
- It issues them one at a time to the memory unit (addr/enable/rwn/data_in, completion via ready/data_valid) and returns one response per request.
- It sits between the CPU core and the SDRAM-backed memory unit, isolating the core from SDRAM init, refresh and busy latency.

---
 rtl/mem_req_pkg.sv | 28 ++
 rtl/req_fifo.sv | 40 ++++
 rtl/mem_requester.sv | 174 +++++++++++++++++
 tb/tb_mem_requester.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// Shared definitions for the memory-unit requester: FSM state codes and the queued request record.
// The record is packed as {rwn, addr, wdata}, rwn in the MSB.
package mem_req_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_RD_DONE = 3'd4;
  localparam logic [2:0] S_WR_DONE = 3'd5;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;

  typedef struct packed {
    logic                  rwn;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // Record width for non-default address/data widths.
  function automatic int req_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Show-ahead synchronous FIFO, depth 2**AW; head is valid combinationally whenever empty=0.
// Zero-latency head; caller must not push when full or pop when empty.
module req_fifo #(
  parameter int W  = 33,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Extra pointer bit separates full (wrapped once) from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mem_requester.sv
// Queues CPU load/store requests and runs them one at a time through the memory-unit handshake.
// One response pulse per request, in order; req_ready drops when the queue is full or in reset.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rwn,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_rwn,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              idle,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_rwn,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  localparam int                 RW      = req_width(ADDR_W, DATA_W);
  localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              timed_out;
  logic [RW-1:0]     head_dat;
  logic              head_rwn;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !fifo_empty && mem_ready;
  assign req_ready = !rst && !fifo_full;
  assign idle      = fifo_empty && (state == S_IDLE);
  assign timed_out = (cnt == CNT_MAX);
  assign {head_rwn, head_addr, head_wdata} = head_dat;

  req_fifo #(
    .W  (RW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({req_rwn, req_addr, req_wdata}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mem_enable  <= 1'b0;
      mem_rwn     <= 1'b1;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rwn     <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Operands are latched here only, so they hold until the next return to IDLE.
          if (pop) begin
            mem_addr    <= head_addr;
            mem_rwn     <= head_rwn;
            mem_data_in <= head_wdata;
            mem_enable  <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_enable <= 1'b0;
          cnt        <= '0;
          state      <= S_ACK;
        end
        S_ACK: begin
          if (!mem_ready) begin
            cnt   <= '0;
            state <= mem_rwn ? S_RD_DATA : S_WR_DONE;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rwn   <= mem_rwn;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_DATA: begin
          if (mem_data_valid) begin
            rsp_rdata <= mem_data_out;
            cnt       <= '0;
            if (mem_ready) begin
              rsp_valid <= 1'b1;
              rsp_rwn   <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_RD_DONE;
            end
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rwn   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_DONE: begin
          if (mem_ready) begin
            rsp_valid <= 1'b1;
            rsp_rwn   <= 1'b1;
            state     <= S_IDLE;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rwn   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_DONE: begin
          if (mem_ready) begin
            rsp_valid <= 1'b1;
            rsp_rwn   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rwn   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          mem_enable <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized bench for mem_requester: a behavioural memory unit plus an in-order response model.
module tb_mem_requester;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rwn;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_rwn, rsp_err, idle;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_enable, mem_rwn;
  logic        mem_ready = 1'b0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data_out = 16'h0;

  mem_requester #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .FIFO_AW (2),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rwn        (req_rwn),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rwn        (rsp_rwn),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .idle           (idle),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_rwn        (mem_rwn),
    .mem_data_in    (mem_data_in),
    .mem_ready      (mem_ready),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        rwn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          to;
  } exp_t;

  exp_t        iss_q[$];
  exp_t        rsp_q[$];
  logic [15:0] ref_mem  [logic [15:0]];
  logic [15:0] unit_mem [logic [15:0]];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_acc = 0, n_rsp = 0, n_drop = 0;
  int en_cnt = 0, en_cyc = 0, last_en_cyc = 0, last_rsp_cyc = 0, prev_rsp_cyc = 0;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory unit model: idle with ready=1; drops ready to take a request, then completes.
  bit          mem_up = 1'b0, fx = 1'b0, fx_sim = 1'b0;
  int          hang_cnt = 0, fx_ack = 1, fx_dv = 1, fx_rdy = 0, fx_wr = 1;
  int          ph = 0, mcnt = 0, m_dv = 1, m_rdy = 0, m_wr = 1;
  bit          m_sim = 1'b0;
  logic        m_rwn;
  logic [15:0] m_addr, m_wdata;

  initial forever begin
    @(posedge clk);
    #1;
    if (rst || !mem_up) begin
      ph = 0;
      mem_ready = mem_up;
      mem_data_valid = 1'b0;
    end else begin
      case (ph)
        0: begin
          mem_ready = 1'b1;
          mem_data_valid = 1'b0;
          if (mem_enable) begin
            if (hang_cnt > 0) hang_cnt--;
            else begin
              m_rwn = mem_rwn; m_addr = mem_addr; m_wdata = mem_data_in;
              if (fx) begin
                mcnt = fx_ack; m_dv = fx_dv; m_rdy = fx_rdy; m_sim = fx_sim; m_wr = fx_wr;
              end else begin
                mcnt = int'($urandom_range(3, 1)); m_dv = int'($urandom_range(4, 1));
                m_rdy = int'($urandom_range(3, 0)); m_wr = int'($urandom_range(4, 1));
                m_sim = ($urandom_range(3, 0) == 0);
              end
              ph = 1;
            end
          end
        end
        1: begin
          mcnt--;
          if (mcnt == 0) begin
            mem_ready = 1'b0;
            if (m_rwn) begin mcnt = m_dv; ph = 2; end
            else begin mcnt = m_wr; ph = 5; end
          end
        end
        2: begin
          mcnt--;
          if (mcnt == 0) begin
            mem_data_valid = 1'b1;
            mem_data_out = unit_mem.exists(m_addr) ? unit_mem[m_addr] : dflt(m_addr);
            if (m_sim) begin mem_ready = 1'b1; ph = 3; end
            else begin mcnt = m_rdy; ph = 4; end
          end
        end
        3: begin mem_data_valid = 1'b0; ph = 0; end
        4: begin
          mem_data_valid = 1'b0;
          if (mcnt == 0) begin mem_ready = 1'b1; ph = 0; end
          else mcnt--;
        end
        default: begin
          mcnt--;
          if (mcnt == 0) begin unit_mem[m_addr] = m_wdata; mem_ready = 1'b1; ph = 0; end
        end
      endcase
    end
  end

  // Monitor: issues and responses checked against the expectation queues.
  logic prev_en = 1'b0;
  exp_t me;
  initial forever begin
    @(negedge clk);
    if (rst) prev_en = 1'b0;
    else begin
      if (mem_enable) begin
        chk("enable_one_cycle", 32'(prev_en), 0);
        if (!prev_en) begin
          en_cnt++; en_cyc = cyc; last_en_cyc = cyc;
          if (iss_q.size() == 0) chk("unexpected_issue", 32'(mem_enable), 0);
          else begin
            me = iss_q.pop_front();
            chk("issue_addr", 32'(mem_addr), 32'(me.addr));
            chk("issue_rwn", 32'(mem_rwn), 32'(me.rwn));
            if (!me.rwn) chk("issue_wdata", 32'(mem_data_in), 32'(me.wdata));
          end
        end
      end
      prev_en = mem_enable;
      if (rsp_valid) begin
        n_rsp++; prev_rsp_cyc = last_rsp_cyc; last_rsp_cyc = cyc;
        if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
        else begin
          me = rsp_q.pop_front();
          chk("rsp_rwn", 32'(rsp_rwn), 32'(me.rwn));
          chk("rsp_err", 32'(rsp_err), 32'(me.to));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(me.rdata));
          chk("addr_stable", 32'(mem_addr), 32'(me.addr));
          if (me.to) chk("timeout_latency", cyc - en_cyc, TO + 2);
        end
      end
    end
  end

  task automatic send(input logic rwn, input logic [15:0] a, input logic [15:0] d, input bit to);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1; req_rwn = rwn; req_addr = a; req_wdata = d;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", 32'(req_ready), 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e.rwn = rwn; e.addr = a; e.wdata = d; e.to = to;
      if (rwn) e.rdata = to ? 16'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
      else begin
        e.rdata = 16'h0;
        if (!to) ref_mem[a] = d;
      end
      iss_q.push_back(e); rsp_q.push_back(e); n_acc++;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || !idle) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_done", rsp_q.size(), 0);
  endtask

  initial begin
    int n, r0;
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, r0;
    rst = 1'b1; req_valid = 1'b0; req_rwn = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready_after", 32'(req_ready), 1);
    chk("rst_mem_enable", 32'(mem_enable), 0);
    chk("rst_mem_rwn", 32'(mem_rwn), 1);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data_in", 32'(mem_data_in), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rwn", 32'(rsp_rwn), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_idle", 32'(idle), 1);

    // Memory not yet initialised: four requests fill the queue, the fifth is refused.
    for (int i = 0; i < 4; i++)
      send(1'($urandom_range(1, 0)), 16'h0040 + 16'(i), 16'($urandom), 1'b0);
    req_valid = 1'b1; req_rwn = 1'b1; req_addr = 16'h0099;
    chk("full_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (44) begin @(posedge clk); #1; end
    chk("no_issue_before_init", en_cnt, 0);
    @(negedge clk) mem_up = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!mem_ready && n < 10);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!mem_enable && n < 20);
    chk("first_issue_latency", n, 1);
    drain();

    // Directed read with fixed unit timing.
    fx = 1'b1; fx_ack = 1; fx_dv = 4; fx_rdy = 0; fx_sim = 1'b0; fx_wr = 2;
    unit_mem[16'h1234] = 16'hBEEF; ref_mem[16'h1234] = 16'hBEEF;
    r0 = n_rsp;
    send(1'b1, 16'h1234, 16'h0, 1'b0);
    drain();
    chk("read_one_rsp", n_rsp - r0, 1);
    chk("read_latency", last_rsp_cyc - last_en_cyc, 7);

    // Write then read the same address back-to-back.
    r0 = n_rsp;
    send(1'b0, 16'h00FF, 16'hA5A5, 1'b0);
    send(1'b1, 16'h00FF, 16'h0, 1'b0);
    drain();
    chk("wr_rd_two_rsp", n_rsp - r0, 2);

    // Unit ignores one request entirely: that one aborts, the next completes.
    fx = 1'b0; hang_cnt = 1;
    send(1'b1, 16'h0200, 16'h0, 1'b1);
    send(1'b0, 16'h0201, 16'h7777, 1'b0);
    drain();

    // Data valid and ready in the same cycle.
    fx = 1'b1; fx_ack = 2; fx_dv = 2; fx_sim = 1'b1;
    send(1'b1, 16'h0300, 16'h0, 1'b0);
    send(1'b1, 16'h0301, 16'h0, 1'b0);
    drain();
    chk("simul_next_issue", last_en_cyc - prev_rsp_cyc, 1);
    chk("simul_rsp_latency", last_rsp_cyc - last_en_cyc, 5);

    // Random traffic over a small address window so reads hit earlier writes.
    fx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) == 0)
        repeat ($urandom_range(4, 1)) begin @(posedge clk); #1; end
      send(1'($urandom_range(1, 0)), 16'h0010 + 16'($urandom_range(7, 0)), 16'($urandom), 1'b0);
    end
    drain();

    // Reset while a read waits for data with two more queued.
    fx = 1'b1; fx_ack = 1; fx_dv = 12; fx_rdy = 0; fx_sim = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, 16'h0500 + 16'(i), 16'h0, 1'b0);
    n = 0;
    while (mem_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("reached_rd_data", 32'(mem_ready), 0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    n_drop = rsp_q.size();
    rsp_q.delete(); iss_q.delete();
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_mem_enable", 32'(mem_enable), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    r0 = en_cnt;
    repeat (20) begin @(posedge clk); #1; end
    chk("no_issue_after_rst", en_cnt - r0, 0);
    chk("idle_after_rst_wait", 32'(idle), 1);

    chk("rsp_count", n_rsp, n_acc - n_drop);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
